// File: rtl/calc_seq_ctrl_pkg.sv
// calc_seq_ctrl_pkg: shared state encodings and display message constants for calc_seq_ctrl
package calc_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADED = 3'd1,
    S_ADD    = 3'd2,
    S_SUB    = 3'd3,
    S_ERR    = 3'd7
  } state_e;
  localparam int MSG_W_DEF = 10;
  localparam logic [MSG_W_DEF-1:0] MESSAGE_DEFAULT = 10'h3FF;
  localparam logic [MSG_W_DEF-1:0] MESSAGE_ERROR   = 10'h3EE;
  localparam int MSG_MINUS_BIT = MSG_W_DEF - 1;
endpackage

// File: rtl/calc_seq_ctrl_btn_edge_detect.sv
// btn_edge_detect: registered one-cycle pulse on a 0->1 button transition; history resets to 1
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic prev_q, prev_d, pulse_q, pulse_d;
  always_comb begin
    prev_d = btn;
    pulse_d = btn & ~prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: load/add/sub calculator controller formatting a 7-segment message.
// Define CALC_ACCUM_EN to chain results into operand A with a sticky flag.
module calc_seq_ctrl
  import calc_seq_ctrl_pkg::*;
#(
  parameter int W = 4,
  parameter int MSG_W = 10
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic [W-1:0]     i_w_operand1,
  input  logic [W-1:0]     i_w_operand2,
  input  logic             i_w_op_ready_button,
  input  logic             i_w_add_button,
  input  logic             i_w_sub_button,
  output logic [W:0]       o_r_result,
  output logic             o_r_flag,
  output logic [2:0]       o_r_state,
  output logic [2*W-1:0]   o_r_leds,
  output logic [MSG_W-1:0] o_r_message
);
`ifdef CALC_ACCUM_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int MINUS_BIT = MSG_W - MSG_W_DEF + MSG_MINUS_BIT;
  localparam logic [MSG_W-1:0] MINUS_MASK = MSG_W'(1) << MINUS_BIT;
  logic ld_p, add_p, sub_p, live, ops_ok, chained;
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W:0] result_q, result_d, sum, diff, mag;
  logic flag_q, flag_d;
  logic [2*W-1:0] leds_q, leds_d;
  logic [MSG_W-1:0] message_q, message_d;
  btn_edge_detect u_ld (.clk(i_w_clk), .rst(i_w_reset), .btn(i_w_op_ready_button), .pulse(ld_p));
  btn_edge_detect u_add (.clk(i_w_clk), .rst(i_w_reset), .btn(i_w_add_button), .pulse(add_p));
  btn_edge_detect u_sub (.clk(i_w_clk), .rst(i_w_reset), .btn(i_w_sub_button), .pulse(sub_p));
  assign sum = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    flag_d = flag_q;
    live = state_q inside {S_IDLE, S_LOADED, S_ADD, S_SUB};
    ops_ok = state_q != S_IDLE;
    chained = STICKY && (state_q == S_ADD || state_q == S_SUB);
    if (!live) begin
      state_d = S_ERR;
    end else if (ld_p) begin
      state_d = S_LOADED;
      a_d = chained ? result_q[W-1:0] : i_w_operand1;
      b_d = i_w_operand2;
      flag_d = flag_q & ~(STICKY & (state_q == S_IDLE));
    end else if (add_p && ops_ok) begin
      state_d = S_ADD;
      result_d = sum;
      flag_d = (STICKY & flag_q) | sum[W];
    end else if (sub_p && ops_ok) begin
      state_d = S_SUB;
      result_d = diff;
      flag_d = (STICKY & flag_q) | (a_q < b_q);
    end
    // a negative SUB result always has bit W set, so it doubles as the sign
    mag = '0 - result_d;
    message_d = (state_d == S_ERR) ? MSG_W'(MESSAGE_ERROR)
              : (state_d == S_ADD) ? MSG_W'(result_d)
              : (state_d == S_SUB && result_d[W]) ? (MSG_W'(mag) | MINUS_MASK)
              : (state_d == S_SUB) ? MSG_W'(result_d)
              : MSG_W'(MESSAGE_DEFAULT);
    leds_d = (state_d == S_IDLE) ? {i_w_operand2, i_w_operand1} : {b_d, a_d};
  end
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      flag_q <= 1'b0;
      leds_q <= '0;
      message_q <= MSG_W'(MESSAGE_DEFAULT);
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      flag_q <= flag_d;
      leds_q <= leds_d;
      message_q <= message_d;
    end
  end
  assign o_r_result = result_q;
  assign o_r_flag = flag_q;
  assign o_r_state = state_q;
  assign o_r_leds = leds_q;
  assign o_r_message = message_q;
endmodule
